// File: rtl/data_interface.sv
// Avalon-MM master for the MAX10 on-chip flash data port: address load and
// single-word read/write, with auto-increment and a one-cycle done pulse.
module data_interface #(
    parameter int ADDR_W  = 17,
    parameter int BURST_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_addr,
    input  logic               start_rddata,
    input  logic               start_wrdata,
    input  logic [31:0]        rw_addr,
    input  logic [31:0]        wr_data,
    output logic [31:0]        rd_data,
    output logic               done,
    output logic [ADDR_W-1:0]  Addr,
    output logic               Read,
    output logic               Write,
    output logic [31:0]        WriteData,
    input  logic [31:0]        ReadData,
    input  logic               WaitRequest,
    input  logic               ReadDataValid,
    output logic [BURST_W-1:0] BurstCount
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        rd_data_q, rd_data_d;
    logic [31:0]        wdata_q, wdata_d;

    // Only the low ADDR_W bits of rw_addr address the flash.
    logic [31-ADDR_W:0] unused_rw_addr;
    assign unused_rw_addr = rw_addr[31:ADDR_W];

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rd_data_d = rd_data_q;
        wdata_d   = wdata_q;
        case (state_q)
            IDLE: begin
                if (start_addr) begin
                    addr_d  = rw_addr[ADDR_W-1:0];
                    state_d = DONE;
                end else if (start_rddata) begin
                    state_d = RD_REQ;
                end else if (start_wrdata) begin
                    wdata_d = wr_data;
                    state_d = WR_REQ;
                end
            end
            RD_REQ: begin
                if (!WaitRequest) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (ReadDataValid) begin
                    rd_data_d = ReadData;
                    addr_d    = addr_q + ADDR_W'(1);
                    state_d   = DONE;
                end
            end
            WR_REQ: begin
                // Flash programming can stall here for a long time; Addr and
                // WriteData stay frozen because nothing else updates them.
                if (!WaitRequest) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rd_data_q <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rd_data_q <= rd_data_d;
            wdata_q   <= wdata_d;
        end
    end

    assign Read       = (state_q == RD_REQ);
    assign Write      = (state_q == WR_REQ);
    assign done       = (state_q == DONE);
    assign Addr       = addr_q;
    assign rd_data    = rd_data_q;
    assign WriteData  = wdata_q;
    assign BurstCount = BURST_W'(1);

endmodule

// File: tb/tb_data_interface.sv
// Bench for data_interface: each command is expanded into its expected
// per-cycle output timeline, which a negedge compare process checks.
module tb_data_interface;
    localparam int ADDR_W  = 17;
    localparam int BURST_W = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               start_addr, start_rddata, start_wrdata;
    logic [31:0]        rw_addr, wr_data, rd_data, WriteData, ReadData;
    logic               done, Read, Write, WaitRequest, ReadDataValid;
    logic [ADDR_W-1:0]  Addr;
    logic [BURST_W-1:0] BurstCount;

    data_interface #(.ADDR_W(ADDR_W), .BURST_W(BURST_W)) dut (
        .clk(clk), .reset(reset),
        .start_addr(start_addr), .start_rddata(start_rddata), .start_wrdata(start_wrdata),
        .rw_addr(rw_addr), .wr_data(wr_data), .rd_data(rd_data), .done(done),
        .Addr(Addr), .Read(Read), .Write(Write), .WriteData(WriteData),
        .ReadData(ReadData), .WaitRequest(WaitRequest), .ReadDataValid(ReadDataValid),
        .BurstCount(BurstCount)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: what each output must show in the current cycle.
    logic              exp_valid = 1'b0;
    logic              exp_read, exp_write, exp_done;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_rd, m_wd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_valid) begin
            chk("Read", 32'(Read), 32'(exp_read));
            chk("Write", 32'(Write), 32'(exp_write));
            chk("done", 32'(done), 32'(exp_done));
            chk("Addr", 32'(Addr), 32'(m_addr));
            chk("rd_data", rd_data, m_rd);
            chk("WriteData", WriteData, m_wd);
            chk("BurstCount", 32'(BurstCount), 32'd1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cyc(input logic r, input logic w, input logic d);
        exp_read  = r;
        exp_write = w;
        exp_done  = d;
    endtask

    task automatic clear_starts();
        start_addr   = 1'b0;
        start_rddata = 1'b0;
        start_wrdata = 1'b0;
    endtask

    // Stray commands and bus noise while busy; all must be ignored.
    task automatic junk(input bit allow);
        start_addr    = allow && ($urandom_range(0, 5) == 0);
        start_rddata  = allow && ($urandom_range(0, 5) == 0);
        start_wrdata  = allow && ($urandom_range(0, 5) == 0);
        rw_addr       = $urandom;
        wr_data       = $urandom;
        ReadData      = $urandom;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            clear_starts();
            rw_addr       = $urandom;
            wr_data       = $urandom;
            ReadData      = $urandom;
            WaitRequest   = 1'($urandom);
            ReadDataValid = 1'($urandom);
            expect_cyc(0, 0, 0);
            step();
        end
    endtask

    task automatic ld_addr(input logic [31:0] a, input bit dual, input bit noisy);
        clear_starts();
        start_addr    = 1'b1;
        start_rddata  = dual;
        start_wrdata  = dual;
        rw_addr       = a;
        ReadDataValid = 1'b0;
        expect_cyc(0, 0, 0);
        step();
        m_addr = a[ADDR_W-1:0];
        junk(noisy);
        expect_cyc(0, 0, 1);
        step();
    endtask

    task automatic do_read(input int waits, input int lat, input logic [31:0] word,
                           input bit dual, input bit wr_in_wait, input bit noisy);
        clear_starts();
        start_rddata  = 1'b1;
        start_wrdata  = dual;
        wr_data       = $urandom;
        ReadDataValid = 1'b0;
        expect_cyc(0, 0, 0);
        step();
        for (int i = 0; i <= waits; i++) begin
            junk(noisy);
            WaitRequest   = (i < waits);
            ReadDataValid = 1'($urandom);
            expect_cyc(1, 0, 0);
            step();
        end
        for (int j = 1; j <= lat; j++) begin
            junk(noisy);
            if (wr_in_wait) start_wrdata = 1'b1;
            WaitRequest   = 1'($urandom);
            ReadDataValid = (j == lat);
            if (j == lat) ReadData = word;
            expect_cyc(0, 0, 0);
            step();
        end
        m_rd   = word;
        m_addr = m_addr + 1'b1;
        junk(noisy);
        ReadDataValid = 1'b0;
        expect_cyc(0, 0, 1);
        step();
    endtask

    task automatic do_write(input int waits, input logic [31:0] data, input bit noisy);
        clear_starts();
        start_wrdata  = 1'b1;
        wr_data       = data;
        ReadDataValid = 1'b0;
        expect_cyc(0, 0, 0);
        step();
        m_wd = data;
        for (int i = 0; i <= waits; i++) begin
            junk(noisy);
            WaitRequest = (i < waits);
            expect_cyc(0, 1, 0);
            step();
        end
        m_addr = m_addr + 1'b1;
        junk(noisy);
        expect_cyc(0, 0, 1);
        step();
    endtask

    initial begin
        logic [31:0] a;
        reset = 1'b1;
        clear_starts();
        rw_addr = '0; wr_data = '0; ReadData = '0;
        WaitRequest = 1'b0; ReadDataValid = 1'b0;
        step();
        m_addr = '0; m_rd = '0; m_wd = '0;
        expect_cyc(0, 0, 0);
        exp_valid = 1'b1;
        step();
        reset = 1'b0;
        idle_cycles(2);

        // Address load
        ld_addr(32'h000154C3, 1'b0, 1'b0);
        chk("pin_load_addr", 32'(Addr), 32'h000154C3);
        idle_cycles(2);

        // Three reads, starts 8 cycles apart, 1-cycle valid latency
        do_read(0, 1, 32'h11111111, 1'b0, 1'b0, 1'b0);
        idle_cycles(4);
        do_read(0, 1, 32'h22222222, 1'b0, 1'b0, 1'b0);
        idle_cycles(4);
        do_read(0, 1, 32'h33333333, 1'b0, 1'b0, 1'b0);
        chk("pin_rd_addr", 32'(Addr), 32'h000154C6);
        chk("pin_rd_data", rd_data, 32'h33333333);
        idle_cycles(2);

        // Stalled write
        ld_addr(32'h0001AB71, 1'b0, 1'b0);
        do_write(10, 32'hA177CD85, 1'b0);
        chk("pin_wr_addr", 32'(Addr), 32'h0001AB72);
        chk("pin_wr_data", WriteData, 32'hA177CD85);
        idle_cycles(2);

        // Simultaneous read+write start, then write pulses during RD_WAIT
        do_read(1, 3, 32'hCAFEF00D, 1'b1, 1'b1, 1'b0);
        idle_cycles(1);
        ld_addr(32'hFFFE0000, 1'b1, 1'b0);
        chk("pin_prio_addr", 32'(Addr), 32'h00000000);
        idle_cycles(1);

        // Wrap
        ld_addr(32'h0001FFFF, 1'b0, 1'b0);
        do_read(0, 1, 32'h5A5A5A5A, 1'b0, 1'b0, 1'b0);
        chk("pin_wrap_addr", 32'(Addr), 32'h00000000);
        idle_cycles(1);

        // Reset during a stalled write: Write drops next cycle, no done
        ld_addr(32'h00000ABC, 1'b0, 1'b0);
        clear_starts();
        start_wrdata = 1'b1;
        wr_data = 32'h12345678;
        expect_cyc(0, 0, 0);
        step();
        m_wd = 32'h12345678;
        clear_starts();
        WaitRequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_cyc(0, 1, 0);
            step();
        end
        reset = 1'b1;
        expect_cyc(0, 1, 0);
        step();
        reset = 1'b0;
        m_addr = '0; m_rd = '0; m_wd = '0;
        WaitRequest = 1'b0;
        expect_cyc(0, 0, 0);
        step();
        chk("pin_rst_write", 32'(Write), 32'd0);
        idle_cycles(4);

        // Randomized traffic
        for (int k = 0; k < 120; k++) begin
            case ($urandom_range(0, 2))
                0: begin
                    a = $urandom;
                    if ($urandom_range(0, 3) == 0) a[ADDR_W-1:0] = '1;
                    ld_addr(a, 1'($urandom), 1'b1);
                end
                1: do_read($urandom_range(0, 4), $urandom_range(1, 3), $urandom,
                           1'($urandom), 1'($urandom), 1'b1);
                default: do_write($urandom_range(0, 6), $urandom, 1'b1);
            endcase
            idle_cycles($urandom_range(0, 2));
        end

        exp_valid = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/data_interface.md
# data_interface

Avalon-MM master that drives the data port of the MAX10 on-chip flash (UFM/CFM) for the dual-image upgrade controller. It latches a word address and performs single-word reads and writes on command. It auto-increments the address after each transfer and signals completion with a one-cycle `done` pulse. It sits beside the CSR-port master (`ControlInterface`), which handles status, control and write-protect; this block never touches the CSR port.

## Interface
Parameters:
- `ADDR_W`, 17: flash data-port word address width.
- `BURST_W`, 4: `BurstCount` width.

Ports:
- `clk` in 1: single system clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start_addr` in 1: one-cycle command that loads the address.
- `start_rddata` in 1: one-cycle command that reads one word.
- `start_wrdata` in 1: one-cycle command that writes one word.
- `rw_addr` in 32: address source; bits [ADDR_W-1:0] are used, the upper bits are ignored.
- `wr_data` in 32: write data, sampled on the `start_wrdata` cycle.
- `rd_data` out 32: last word read; held until the next read completes.
- `done` out 1: one-cycle completion pulse for any command.
- `Addr` out ADDR_W: Avalon address (the internal address register).
- `Read` out 1: Avalon read request.
- `Write` out 1: Avalon write request.
- `WriteData` out 32: Avalon write data.
- `ReadData` in 32: Avalon read data.
- `WaitRequest` in 1: Avalon slave stall.
- `ReadDataValid` in 1: Avalon read data valid.
- `BurstCount` out BURST_W: constant 1.

## Operation
- Clocking and reset: one clock domain; `reset` is synchronous and active-high.
- State machine states: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
- IDLE: commands are accepted only here, with priority `start_addr` > `start_rddata` > `start_wrdata`.
  - Command pulses arriving in any other state are ignored, not queued.
- `start_addr`: address register <= `rw_addr[ADDR_W-1:0]`; go to DONE.
- `start_rddata`: go to RD_REQ.
  - RD_REQ: `Read`=1; hold while `WaitRequest`=1.
  - When `WaitRequest`=0, the command is accepted; go to RD_WAIT.
  - RD_WAIT: `Read`=0. On `ReadDataValid`=1: `rd_data` <= `ReadData`; address <= address+1; go to DONE.
- `start_wrdata`: `WriteData` <= `wr_data`; go to WR_REQ.
  - WR_REQ: `Write`=1; hold `Addr`/`WriteData` stable while `WaitRequest`=1. This can last many cycles during flash programming.
  - When `WaitRequest`=0, the command is accepted; address <= address+1; go to DONE.
- DONE: `done`=1 for exactly one cycle; return to IDLE.
- Address increment wraps modulo 2^ADDR_W, so 0x1FFFF+1 = 0x00000.
- `ReadDataValid` outside RD_WAIT is ignored. `BurstCount` is tied to 1.
- There is no timeout. Erase, write-protect and status checks belong to the CSR-port master.

## Timing
- Reset values: state IDLE, `Read`=0, `Write`=0, `done`=0, `Addr`=0, `rd_data`=0, `WriteData`=0, `BurstCount`=1.
- Commands are sampled at the posedge. `Read`/`Write` is asserted in the first cycle after the start cycle.
- Minimum read latency, with `WaitRequest` low and `ReadDataValid` one cycle after acceptance:
  - start → `Read` high 1 cycle → RD_WAIT 1 cycle → `done` high.
  - Total: `done` in cycle 4 after the start cycle.
- Minimum write latency: `done` in cycle 3 after the start cycle.
- Load-address latency: `done` in cycle 2 after the start cycle; the new `Addr` is visible in the same cycle as `done`.
- `rd_data` and the incremented `Addr` are valid when `done` is high.
- Reset mid-operation: the next edge forces IDLE and drops `Read`/`Write` immediately; no `done` is produced.
- Simultaneous `start_*` pulses: only the highest-priority command executes.

## Test plan
- Reset behaviour: hold `reset` 2 cycles → all outputs at reset values, `BurstCount`=1.
- Address load: `rw_addr`=0x000154C3 with `start_addr` → `Addr`=0x154C3, one `done` pulse.
- Consecutive reads: three `start_rddata` pulses spaced 8 cycles apart, slave returning 0x11111111, 0x22222222, 0x33333333 with 1-cycle `ReadDataValid` latency.
  - Each read → `Read` asserted with `Addr`=0x154C3, 0x154C4, 0x154C5.
  - `rd_data` equals the returned word when `done` pulses.
  - Final `Addr`=0x154C6.
- Stalled write: `rw_addr`=0x0001AB71 loaded, `wr_data`=0xA177CD85 with `start_wrdata`, `WaitRequest` held high 10 cycles.
  - `Write`=1 with `Addr`=0x1AB71 and `WriteData`=0xA177CD85 stable for all 11 cycles.
  - `done` pulses once afterwards; `Addr`=0x1AB72.
- Simultaneous commands and busy drop:
  - `start_rddata` and `start_wrdata` in the same cycle → only a read occurs.
  - `start_wrdata` issued during RD_WAIT → ignored, no `Write`.
- Wrap and reset mid-operation:
  - Load 0x1FFFF, then read → `Addr` becomes 0x00000.
  - Assert `reset` during WR_REQ → `Write`=0 on the next cycle, no `done`.
